// File: rtl/dec_sync.sv
// Clocked 2-to-4 decoder: rebuilds the request line from an encoded index,
// giving a one-cycle pulse, a HOLD-cycle stretched level and a saturating event count.
module dec_sync #(
    parameter int HOLD  = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       in_idx,
    input  logic             in_valid,
    output logic [3:0]       pulse,
    output logic [3:0]       out,
    output logic             active,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam logic [3:0]       HOLD_C  = 4'(HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       dec_s;
    logic [3:0]       pulse_r;
    logic [3:0][3:0]  hold_cnt_r;
    logic [3:0]       out_s;
    logic [CNT_W-1:0] evt_cnt_r;

    // Index 00 is the highest-priority line 3, so the line number is 3 - in_idx.
    always_comb begin
        dec_s = 4'b0000;
        if (in_valid) begin
            dec_s = 4'b0001 << (2'd3 - in_idx);
        end else begin
            dec_s = 4'b0000;
        end
    end

    // One-cycle pulse register, one cycle behind the accepted event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_r <= 4'b0000;
        end else begin
            pulse_r <= dec_s;
        end
    end

    // Per-line hold counters: reload on an event, otherwise count down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (dec_s[i]) begin
                    hold_cnt_r[i] <= HOLD_C;
                end else if (hold_cnt_r[i] != 4'd0) begin
                    hold_cnt_r[i] <= hold_cnt_r[i] - 4'd1;
                end
            end
        end
    end

    // Saturating event counter; it never wraps back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt_r <= '0;
        end else if (in_valid && (evt_cnt_r != CNT_MAX)) begin
            evt_cnt_r <= evt_cnt_r + CNT_ONE;
        end
    end

    // Stretched levels come only from register state, so they cannot glitch on inputs.
    always_comb begin
        out_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            out_s[i] = (hold_cnt_r[i] != 4'd0);
        end
    end

    assign pulse   = pulse_r;
    assign out     = out_s;
    assign active  = |out_s;
    assign evt_cnt = evt_cnt_r;

endmodule

// File: tb/tb_dec_sync.sv
// Bench for dec_sync: a directed vector table, hand-written reset/saturation sequences,
// and random traffic checked against an event-time reference model.
module tb_dec_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_idx;
    logic       in_valid;

    logic [3:0] pulse0, out0, pulse1, out1;
    logic       active0, active1;
    logic [7:0] cnt0;
    logic [2:0] cnt1;

    dec_sync #(.HOLD(3), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .in_idx(in_idx), .in_valid(in_valid),
        .pulse(pulse0), .out(out0), .active(active0), .evt_cnt(cnt0)
    );

    dec_sync #(.HOLD(1), .CNT_W(3)) u1 (
        .clk(clk), .rst(rst), .in_idx(in_idx), .in_valid(in_valid),
        .pulse(pulse1), .out(out1), .active(active1), .evt_cnt(cnt1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: remembers the edge number of the latest event per line.
    int         cyc;
    int         last_ev[4];
    bit         seen[4];
    int         total;
    logic [3:0] m_pulse;

    typedef struct {
        logic       v;
        logic [1:0] idx;
        logic [3:0] p;
        logic [3:0] o;
        logic [7:0] c;
    } vec_t;

    vec_t tbl[23];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        total = 0;
        m_pulse = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            seen[i] = 1'b0;
            last_ev[i] = 0;
        end
    endtask

    function automatic logic [3:0] exp_out(input int hold);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (seen[i] && (cyc - last_ev[i]) < hold) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    // Drive one cycle, advance the model on the edge, compare at the falling edge.
    task automatic tick(input logic v, input logic [1:0] idx);
        int l;
        in_valid = v;
        in_idx   = idx;
        @(posedge clk);
        cyc++;
        m_pulse = 4'b0000;
        if (v) begin
            l = 3 - int'(idx);
            seen[l] = 1'b1;
            last_ev[l] = cyc;
            m_pulse[l] = 1'b1;
            total++;
        end
        @(negedge clk);
        check("u0.pulse",  32'(pulse0),  32'(m_pulse));
        check("u0.out",    32'(out0),    32'(exp_out(3)));
        check("u0.active", 32'(active0), 32'(|exp_out(3)));
        check("u0.evt_cnt", 32'(cnt0),   32'(sat(total, 255)));
        check("u1.pulse",  32'(pulse1),  32'(m_pulse));
        check("u1.out",    32'(out1),    32'(exp_out(1)));
        check("u1.out_eq_pulse", 32'(out1), 32'(pulse1));
        check("u1.evt_cnt", 32'(cnt1),   32'(sat(total, 7)));
    endtask

    task automatic check_zero(input string nm);
        check({nm, ".pulse0"}, 32'(pulse0), 32'd0);
        check({nm, ".out0"},   32'(out0),   32'd0);
        check({nm, ".active0"}, 32'(active0), 32'd0);
        check({nm, ".cnt0"},   32'(cnt0),   32'd0);
        check({nm, ".cnt1"},   32'(cnt1),   32'd0);
    endtask

    initial begin
        // Directed table (HOLD=3): single event, mapping sweep, retrigger and overlap.
        tbl[0]  = '{1'b1, 2'b00, 4'b1000, 4'b1000, 8'd1};
        tbl[1]  = '{1'b0, 2'b00, 4'b0000, 4'b1000, 8'd1};
        tbl[2]  = '{1'b0, 2'b11, 4'b0000, 4'b1000, 8'd1};
        tbl[3]  = '{1'b0, 2'b01, 4'b0000, 4'b0000, 8'd1};
        tbl[4]  = '{1'b1, 2'b01, 4'b0100, 4'b0100, 8'd2};
        tbl[5]  = '{1'b0, 2'b00, 4'b0000, 4'b0100, 8'd2};
        tbl[6]  = '{1'b0, 2'b00, 4'b0000, 4'b0100, 8'd2};
        tbl[7]  = '{1'b0, 2'b00, 4'b0000, 4'b0000, 8'd2};
        tbl[8]  = '{1'b1, 2'b10, 4'b0010, 4'b0010, 8'd3};
        tbl[9]  = '{1'b0, 2'b00, 4'b0000, 4'b0010, 8'd3};
        tbl[10] = '{1'b0, 2'b00, 4'b0000, 4'b0010, 8'd3};
        tbl[11] = '{1'b0, 2'b00, 4'b0000, 4'b0000, 8'd3};
        tbl[12] = '{1'b1, 2'b11, 4'b0001, 4'b0001, 8'd4};
        tbl[13] = '{1'b0, 2'b00, 4'b0000, 4'b0001, 8'd4};
        tbl[14] = '{1'b0, 2'b00, 4'b0000, 4'b0001, 8'd4};
        tbl[15] = '{1'b0, 2'b00, 4'b0000, 4'b0000, 8'd4};
        tbl[16] = '{1'b1, 2'b11, 4'b0001, 4'b0001, 8'd5};
        tbl[17] = '{1'b0, 2'b00, 4'b0000, 4'b0001, 8'd5};
        tbl[18] = '{1'b1, 2'b11, 4'b0001, 4'b0001, 8'd6};
        tbl[19] = '{1'b1, 2'b01, 4'b0100, 4'b0101, 8'd7};
        tbl[20] = '{1'b0, 2'b00, 4'b0000, 4'b0101, 8'd7};
        tbl[21] = '{1'b0, 2'b00, 4'b0000, 4'b0100, 8'd7};
        tbl[22] = '{1'b0, 2'b00, 4'b0000, 4'b0000, 8'd7};

        rst = 1'b1;
        in_valid = 1'b0;
        in_idx = 2'b00;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Idle with a wandering or unknown index: nothing may appear.
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, (i % 3 == 0) ? 2'bxx : 2'($urandom));
            check("idle.out0", 32'(out0), 32'd0);
        end

        for (int i = 0; i < 23; i++) begin
            tick(tbl[i].v, tbl[i].idx);
            check($sformatf("tbl%0d.pulse", i), 32'(pulse0), 32'(tbl[i].p));
            check($sformatf("tbl%0d.out", i),   32'(out0),   32'(tbl[i].o));
            check($sformatf("tbl%0d.cnt", i),   32'(cnt0),   32'(tbl[i].c));
        end

        // Reset asserted mid-hold, between edges: outputs must clear without a clock.
        tick(1'b1, 2'b10);
        tick(1'b0, 2'b00);
        check("pre_rst.out0", 32'(out0), 32'b0010);
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 2'b00);
        end
        check_zero("post_rst");

        // Saturation of the 3-bit counter.
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 2'($urandom));
            if (i >= 6) check("sat.cnt1", 32'(cnt1), 32'd7);
        end
        check("sat.cnt0", 32'(cnt0), 32'd10);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom % 3) != 0, 2'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dec_sync.md
Name: dec_sync

Overview:
- Clocked 2-to-4 decoder with pulse stretching. It is the receiving end of the 4-to-2 priority-encoder interface, taking an index and valid bit and rebuilding the request line.
- It drives each decoded line as a single-cycle pulse and as a stretched level held for HOLD cycles. It also keeps a saturating count of accepted events.
- It sits downstream of the priority encoder and drives indicator and enable logic that needs a stable, glitch-free level.

Parameters:
HOLD, 3, number of cycles each stretched output line stays high after an event; legal range 1..15.
CNT_W, 8, width of the saturating event counter.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
in_idx  input  2  encoded line index; 00 = line 3 (highest priority), 01 = line 2, 10 = line 1, 11 = line 0
in_valid  input  1  qualifies in_idx; 0 = no event this cycle
pulse  output  4  registered one-hot, high for exactly 1 cycle per accepted event
out  output  4  stretched lines; may be multi-hot
active  output  1  OR of out
evt_cnt  output  CNT_W  number of accepted events, saturating at all-ones

Behaviour:
- Reset (async assert, synchronous deassert handled upstream):
  - pulse=0, out=0, active=0, evt_cnt=0, all per-line hold counters=0.
  - Assertion mid-hold clears everything immediately, without waiting for a clock edge.
  - After release nothing reasserts until a new event is accepted.
- Event: in_valid=1 sampled at rising edge k.
  - Decoded line L = 3 - in_idx, i.e. the exact inverse of the encoder mapping.
  - in_idx is ignored, and may be X, when in_valid=0.
- pulse:
  - pulse[L]=1 during cycle k+1 only; all other bits 0.
  - Back-to-back events give back-to-back pulses.
  - Latency is 1 cycle.
- Hold counters, one per line, each 4 bits wide:
  - On an event for line i: cnt[i] <= HOLD.
  - Otherwise, if cnt[i]!=0: cnt[i] <= cnt[i]-1.
  - out[i] = (cnt[i]!=0), decoded from registers only, never from inputs.
  - A single event therefore keeps out[L] high for cycles k+1 .. k+HOLD inclusive.
- Retrigger:
  - A new event on a line that is already high reloads its counter to HOLD, extending the level with no gap.
  - No reload occurs on other lines.
- Overlap:
  - Events on different lines within the HOLD window produce a multi-hot out.
  - Each line's counter runs independently.
- HOLD=1: out is identical to pulse, cycle for cycle.
- evt_cnt:
  - Increments by 1 on each accepted event.
  - Holds at 2^CNT_W-1 once reached; it does not wrap.
  - Cleared only by rst.
- active: combinational OR of the registered out bits; glitch-free.
- No backpressure: every in_valid=1 cycle is accepted. At most one event can arrive per cycle, so no same-cycle conflict exists.

Test Plan:
- Reset then idle, in_valid=0 with in_idx toggling or X -> pulse=0, out=0, active=0 and evt_cnt=0 for 20 cycles.
- HOLD=3, single event in_idx=00 at edge k -> pulse=1000 in cycle k+1 only; out=1000 in cycles k+1..k+3; out=0000 at k+4; evt_cnt=1.
- Full mapping sweep with idx 00,01,10,11 at 4-cycle spacing -> pulses 1000, 0100, 0010, 0001 in order; evt_cnt=4.
- Retrigger and overlap: idx=11 at k, idx=11 at k+2, idx=01 at k+3 (HOLD=3) ->
  - out[0] high k+1..k+5 with no gap;
  - out[2] high k+4..k+6;
  - out=0101 at k+4..k+5.
- Reset mid-hold: event idx=10, then rst pulsed between clock edges one cycle later -> out, pulse and evt_cnt drop to 0 before the next edge and stay 0 after release.
- Saturation with CNT_W=3: 10 consecutive valid events -> evt_cnt reaches 7 and holds at 7; with HOLD=1, out equals pulse every cycle.
